// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the FFT frame loader slice.
package fft_pkg;

   localparam int FFT_DW    = 8;
   localparam int FFT_N     = 8;
   localparam int FFT_LOG2N = $clog2(FFT_N);

   // 'real' is a reserved word, hence re/im
   typedef struct packed {
      logic [FFT_DW-1:0] re;
      logic [FFT_DW-1:0] im;
   } cplx_t;

   typedef enum logic {FILL, WAIT_SWAP} state_t;

   // Reverse the low nbits of v; generic so any N can use it
   function automatic int bitrev(input int v, input int nbits);
      int r;
      r = 0;
      for (int i = 0; i < nbits; i++) r = (r << 1) | ((v >> i) & 1);
      return r;
   endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample stream in, parallel frame out, between a sample source and the FFT loader.
interface fft_frame_loader_if
   import fft_pkg::*;
#(
   parameter int DW = FFT_DW,
   parameter int N  = FFT_N
);
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_real;
   logic [DW-1:0] in_img;
   logic [N*DW-1:0] x_real_flat;
   logic [N*DW-1:0] x_img_flat;
   logic          frame_valid;

   modport master (
      output flush, in_valid, in_real, in_img,
      input  in_ready, x_real_flat, x_img_flat, frame_valid
   );

   modport slave (
      input  flush, in_valid, in_real, in_img,
      output in_ready, x_real_flat, x_img_flat, frame_valid
   );
endinterface

// File: rtl/fft_sample_bank.sv
// N-entry complex register file; single write port, whole contents read out in parallel.
module fft_sample_bank #(
   parameter int DW = 8,
   parameter int N  = 8,
   parameter int AW = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic [DW-1:0]        wdata_re,
   input  logic [DW-1:0]        wdata_im,
   output logic [N-1:0][DW-1:0] rd_re,
   output logic [N-1:0][DW-1:0] rd_im
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_re <= '0;
         rd_im <= '0;
      end else if (clear) begin
         rd_re <= '0;
         rd_im <= '0;
      end else if (we) begin
         rd_re[waddr] <= wdata_re;
         rd_im[waddr] <= wdata_im;
      end
   end

endmodule

// File: rtl/fft_frame_loader.sv
// Double-buffered serial-to-parallel frame loader feeding the DIT FFT.
// Define FFT_LOADER_BITREV_EN to present frames in bit-reversed slot order.
module fft_frame_loader
   import fft_pkg::*;
#(
   parameter int DW          = FFT_DW,
   parameter int N           = FFT_N,
   parameter int HOLD_CYCLES = N
) (
   input  logic             clk,
   input  logic             rst,
   fft_frame_loader_if.slave bus
);

   localparam int LOG2N    = $clog2(N);
   localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
   localparam int HW       = $clog2(HOLD_EFF + 1);

   state_t                state, state_nx;
   logic [LOG2N-1:0]      wr_cnt, waddr;
   logic [HW-1:0]         hold_cnt;
   logic                  accept, we, last, hold_ok, swap;
   logic [N-1:0][DW-1:0]  bank_re, bank_im;
   logic [N-1:0][DW-1:0]  nx_re, nx_im;
   logic [N-1:0][DW-1:0]  out_re, out_im;
   logic                  frame_valid_q;

   assign bus.in_ready    = (state == FILL);
   assign accept          = bus.in_valid & bus.in_ready;
   assign we              = accept & ~bus.flush;
   assign last            = we && (wr_cnt == LOG2N'(N - 1));
   assign hold_ok         = (hold_cnt == '0);
   assign bus.x_real_flat = out_re;
   assign bus.x_img_flat  = out_im;
   assign bus.frame_valid = frame_valid_q;

`ifdef FFT_LOADER_BITREV_EN
   assign waddr = LOG2N'(bitrev(int'(wr_cnt), LOG2N));
`else
   assign waddr = wr_cnt;
`endif

   fft_sample_bank #(.DW(DW), .N(N), .AW(LOG2N)) u_fill_bank (
      .clk      (clk),
      .rst      (rst),
      .clear    (bus.flush),
      .we       (we),
      .waddr    (waddr),
      .wdata_re (bus.in_real),
      .wdata_im (bus.in_img),
      .rd_re    (bank_re),
      .rd_im    (bank_im)
   );

   // A swap on the last accept must include the sample the bank is only now writing
   always_comb begin
      nx_re = bank_re;
      nx_im = bank_im;
      if (we) begin
         nx_re[waddr] = bus.in_real;
         nx_im[waddr] = bus.in_img;
      end
   end

   always_comb begin
      state_nx = state;
      swap     = 1'b0;
      case (state)
         FILL: begin
            if (last) begin
               if (hold_ok) swap = 1'b1;
               else         state_nx = WAIT_SWAP;
            end
         end
         WAIT_SWAP: begin
            if (bus.flush) begin
               state_nx = FILL;
            end else if (hold_ok) begin
               swap     = 1'b1;
               state_nx = FILL;
            end
         end
         default: state_nx = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= FILL;
         wr_cnt   <= '0;
         hold_cnt <= '0;
      end else begin
         state <= state_nx;
         if (bus.flush)  wr_cnt <= '0;
         else if (we)    wr_cnt <= wr_cnt + 1'b1;
         if (swap)                 hold_cnt <= HW'(HOLD_EFF - 1);
         else if (hold_cnt != '0)  hold_cnt <= hold_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_re        <= '0;
         out_im        <= '0;
         frame_valid_q <= 1'b0;
      end else begin
         frame_valid_q <= swap;
         if (swap) begin
            out_re <= nx_re;
            out_im <= nx_im;
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed, table-driven bench for fft_frame_loader (N=8, DW=8).
module tb_fft_frame_loader;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fft_frame_loader_if #(.DW(8), .N(8)) bus ();
   fft_frame_loader_if #(.DW(8), .N(8)) bus12 ();

   fft_frame_loader #(.DW(8), .N(8), .HOLD_CYCLES(8))  dut   (.clk(clk), .rst(rst), .bus(bus));
   fft_frame_loader #(.DW(8), .N(8), .HOLD_CYCLES(12)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

   typedef struct {
      logic        vld;
      logic        fl;
      logic [7:0]  re;
      logic [7:0]  im;
      logic        efv;
      logic        erdy;
      logic        chk;
      logic [63:0] ere;
      logic [63:0] eim;
   } vec_t;

   vec_t tv[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic vec_t mk(input logic vld, input logic fl, input logic [7:0] re,
                               input logic [7:0] im, input logic efv, input logic chk,
                               input logic [63:0] ere, input logic [63:0] eim);
      vec_t v;
      v.vld = vld; v.fl = fl; v.re = re; v.im = im;
      v.efv = efv; v.erdy = 1'b1; v.chk = chk; v.ere = ere; v.eim = eim;
      return v;
   endfunction

   // Expected frames are written in natural order; remap for the bit-reversed build
   function automatic logic [63:0] ord(input logic [63:0] nat);
`ifdef FFT_LOADER_BITREV_EN
      logic [63:0] o;
      logic [2:0]  s, r;
      o = '0;
      for (int k = 0; k < 8; k++) begin
         s = 3'(k);
         r = {s[0], s[1], s[2]};
         o[int'(r)*8 +: 8] = nat[k*8 +: 8];
      end
      return o;
`else
      return nat;
`endif
   endfunction

   task automatic check(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s #%0d got=%h want=%h", nm, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      bus.in_valid = v.vld;
      bus.flush    = v.fl;
      bus.in_real  = v.re;
      bus.in_img   = v.im;
      @(posedge clk); #1;
      check("frame_valid", idx, 64'(bus.frame_valid), 64'(v.efv));
      check("in_ready", idx, 64'(bus.in_ready), 64'(v.erdy));
      if (v.chk) begin
         check("x_real_flat", idx, bus.x_real_flat, ord(v.ere));
         check("x_img_flat", idx, bus.x_img_flat, ord(v.eim));
      end
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
   endtask

   localparam logic [63:0] F2_RE = 64'h0000000001010101;
   localparam logic [63:0] F4_RE = 64'h0102030408070605;
   localparam logic [63:0] F4_IM = 64'h1112131418171615;
   localparam logic [63:0] F5_RE = 64'h0303030303030303;
   localparam logic [63:0] F5_IM = 64'hFDFDFDFDFDFDFDFD;
   localparam logic [63:0] FA_RE = 64'h7766554433221100;
   localparam logic [63:0] FA_IM = 64'h8786858483828180;
   localparam logic [63:0] FB_RE = 64'h8786858483828180;
   localparam logic [63:0] FB_IM = 64'h78797A7B7C7D7E7F;
   localparam logic [63:0] F6_RE = 64'h7F7F7F7F7F7F7F7F;
   localparam logic [63:0] F6_IM = 64'h8181818181818181;

   initial begin
      logic [7:0] seq4 [8];
      logic       acc;
      int         n, fvc, t1, t2, low;

      bus.in_valid = 1'b0; bus.flush = 1'b0; bus.in_real = '0; bus.in_img = '0;
      bus12.in_valid = 1'b0; bus12.flush = 1'b0; bus12.in_real = '0; bus12.in_img = '0;

      // frame of 1,1,1,1,0,0,0,0
      for (int k = 0; k < 8; k++)
         tv.push_back(mk(1'b1, 1'b0, (k < 4) ? 8'd1 : 8'd0, 8'd0, k == 7, k == 7, F2_RE, '0));
      tv.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, F2_RE, '0));
      // partial frame, flush with a coincident sample, then a full frame
      for (int k = 0; k < 3; k++)
         tv.push_back(mk(1'b1, 1'b0, 8'd9, 8'd9, 1'b0, 1'b0, '0, '0));
      tv.push_back(mk(1'b1, 1'b1, 8'h55, 8'h55, 1'b0, 1'b1, F2_RE, '0));
      seq4 = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd4, 8'd3, 8'd2, 8'd1};
      for (int k = 0; k < 8; k++)
         tv.push_back(mk(1'b1, 1'b0, seq4[k], seq4[k] + 8'h10, k == 7, k == 7, F4_RE, F4_IM));
      tv.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, F4_RE, F4_IM));
      // in_valid toggling; gap cycles carry junk data
      for (int k = 0; k < 16; k++)
         tv.push_back(mk(k % 2 == 0, 1'b0, (k % 2 == 0) ? 8'd3 : 8'h77, (k % 2 == 0) ? 8'hFD : 8'h77,
                         k == 14, k >= 14, F5_RE, F5_IM));
      for (int k = 0; k < 3; k++)
         tv.push_back(mk(1'b0, 1'b0, 8'h77, 8'h77, 1'b0, 1'b1, F5_RE, F5_IM));
      // two frames streamed back-to-back, no stall at HOLD_CYCLES == N
      for (int k = 0; k < 16; k++)
         tv.push_back(mk(1'b1, 1'b0,
                         (k < 8) ? 8'(k * 17) : 8'(8'h80 + k - 8),
                         (k < 8) ? 8'(8'h80 + k) : 8'(8'h7F - (k - 8)),
                         k == 7 || k == 15, k == 7 || k == 15,
                         (k < 8) ? FA_RE : FB_RE, (k < 8) ? FA_IM : FB_IM));

      // reset state
      #2;
      check("rst_real", 0, bus.x_real_flat, '0);
      check("rst_img", 0, bus.x_img_flat, '0);
      check("rst_fv", 0, 64'(bus.frame_valid), 64'd0);
      #10 rst = 1'b1;
      #1;
      check("rst_ready", 0, 64'(bus.in_ready), 64'd1);
      check("rst_ready12", 0, 64'(bus12.in_ready), 64'd1);
      @(posedge clk); #1;

      foreach (tv[i]) apply(tv[i], i);

      // reset mid-fill: 5 accepts then an async pulse between edges
      for (int k = 0; k < 5; k++)
         apply(mk(1'b1, 1'b0, 8'h11, 8'h11, 1'b0, 1'b0, '0, '0), 100 + k);
      rst = 1'b0;
      #1;
      check("midrst_real", 0, bus.x_real_flat, '0);
      check("midrst_img", 0, bus.x_img_flat, '0);
      check("midrst_fv", 0, 64'(bus.frame_valid), 64'd0);
      #1 rst = 1'b1;
      #1;
      check("midrst_ready", 0, 64'(bus.in_ready), 64'd1);
      for (int k = 0; k < 8; k++)
         apply(mk(1'b1, 1'b0, 8'h7F, 8'h81, k == 7, 1'b1,
                  (k == 7) ? F6_RE : '0, (k == 7) ? F6_IM : '0), 200 + k);

      // HOLD_CYCLES=12: second frame has to wait for the hold window
      n = 0; fvc = 0; t1 = -1; t2 = -1; low = 0;
      bus12.in_valid = 1'b1; bus12.in_real = 8'd0; bus12.in_img = 8'd0;
      for (int c = 0; c < 60 && fvc < 2; c++) begin
         acc = bus12.in_ready & bus12.in_valid;
         @(posedge clk); #1;
         if (acc) n++;
         if (bus12.frame_valid) begin
            fvc++;
            if (fvc == 1) t1 = c; else t2 = c;
         end
         if (n >= 16 && !bus12.in_ready) low++;
         bus12.in_valid = (n < 16);
         bus12.in_real  = 8'(n);
      end
      bus12.in_valid = 1'b0;
      check("h12_frames", 0, 64'(fvc), 64'd2);
      check("h12_first", 0, 64'(t1), 64'd7);
      check("h12_gap", 0, 64'(t2 - t1), 64'd12);
      check("h12_stall", 0, 64'(low), 64'd4);
      check("h12_real", 0, bus12.x_real_flat, ord(64'h0F0E0D0C0B0A0908));
      check("h12_img", 0, bus12.x_img_flat, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
